// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
//
// Pulls words from a show-ahead-free FIFO (read data valid the cycle after the
// read strobe) and sends each one as an asynchronous serial frame:
// start bit, DATA_WIDTH data bits LSB first, optional even parity bit, and
// STOP_BITS stop bits. Every bit lasts CLKS_PER_BIT clock cycles.
//
// Build option:
//   FIFO_UART_TX_PARITY_EN  defined   -> even parity bit sent after the data
//                           undefined -> no parity state, DATA goes to STOP
//
// Ports:
//   i_clk     clock, rising edge
//   i_rst_n   asynchronous active-low reset
//   i_en      permits fetching a new word (sampled in IDLE and at end of STOP)
//   i_empty   FIFO empty flag
//   i_data    FIFO read data, valid the cycle after o_rd
//   o_rd      FIFO read strobe, one-cycle pulse in FETCH
//   o_tx      serial line, idle high
//   o_busy    high in every state except IDLE
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | line high, waiting for i_en=1 with a non-empty FIFO
// FETCH  | o_rd pulse to the FIFO
// LATCH  | FIFO data valid, captured into the shift register on exit
// START  | start bit (low) for CLKS_PER_BIT cycles
// DATA   | DATA_WIDTH bits, LSB first, CLKS_PER_BIT cycles each
// PARITY | even parity bit (only with FIFO_UART_TX_PARITY_EN)
// STOP   | STOP_BITS high bits; then FETCH again or back to IDLE
// -----------------------------------------------------------------------------
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int DATA_WIDTH   = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic                  i_empty,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_rd,
    output logic                  o_tx,
    output logic                  o_busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    // DATA_WIDTH >= 5 keeps this at least 3 bits, so the same index also
    // counts the (at most two) stop bits.
    localparam int IDX_W = $clog2(DATA_WIDTH);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LATCH  = 3'd2,
        S_START  = 3'd3,
        S_DATA   = 3'd4,
`ifdef FIFO_UART_TX_PARITY_EN
        S_PARITY = 3'd5,
`endif
        S_STOP   = 3'd6
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                  par_q, par_d;
`endif

    logic bit_done;
    logic can_fetch;

    assign bit_done  = (cnt_q == CNT_LAST);
    assign can_fetch = i_en & ~i_empty;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
`ifdef FIFO_UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (can_fetch) state_d = S_FETCH;
            S_FETCH:  state_d = S_LATCH;
            S_LATCH:  state_d = S_START;
            S_START:  if (bit_done) state_d = S_DATA;
            S_DATA: begin
                if (bit_done && (idx_q == DATA_LAST)) begin
`ifdef FIFO_UART_TX_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            S_PARITY: if (bit_done) state_d = S_STOP;
`endif
            S_STOP: begin
                if (bit_done && (idx_q == STOP_LAST)) begin
                    state_d = can_fetch ? S_FETCH : S_IDLE;
                end
            end
            default:  state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next values: baud counter, bit index, shift register
    // ------------------------------------------------------------------
    // The baud counter wraps on every bit boundary; since every exit from a
    // timed state happens on a bit boundary and the untimed states hold it
    // at zero, it is zero on entry to every state.
    always_comb begin
        cnt_d   = '0;
        idx_d   = idx_q;
        shift_d = shift_q;
`ifdef FIFO_UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_LATCH: begin
                shift_d = i_data;
`ifdef FIFO_UART_TX_PARITY_EN
                par_d   = ^i_data;
`endif
            end
            S_START: begin
                cnt_d = bit_done ? '0 : cnt_q + 1'b1;
            end
            S_DATA: begin
                cnt_d = bit_done ? '0 : cnt_q + 1'b1;
                if (bit_done) begin
                    shift_d = shift_q >> 1;
                    idx_d   = (idx_q == DATA_LAST) ? '0 : idx_q + 1'b1;
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            S_PARITY: begin
                cnt_d = bit_done ? '0 : cnt_q + 1'b1;
            end
`endif
            S_STOP: begin
                cnt_d = bit_done ? '0 : cnt_q + 1'b1;
                if (bit_done) begin
                    idx_d = (idx_q == STOP_LAST) ? '0 : idx_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Moore output decode (state and registered datapath only)
    // ------------------------------------------------------------------
    always_comb begin
        o_rd   = 1'b0;
        o_tx   = 1'b1;
        o_busy = 1'b1;
        case (state_q)
            S_IDLE:   o_busy = 1'b0;
            S_FETCH:  o_rd   = 1'b1;
            S_START:  o_tx   = 1'b0;
            S_DATA:   o_tx   = shift_q[0];
`ifdef FIFO_UART_TX_PARITY_EN
            S_PARITY: o_tx   = par_q;
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
module tb_fifo_uart_tx;

    localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NB  = 11;
`else
    localparam int NB  = 10;
`endif
    localparam int PAR = NB - 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       en;
    logic       empty;
    logic [7:0] data = 8'h00;
    logic       rd, tx, busy;

    logic       en2, empty2;
    logic [7:0] data2;
    logic       rd2, tx2, busy2;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_en    (en),
        .i_empty (empty),
        .i_data  (data),
        .o_rd    (rd),
        .o_tx    (tx),
        .o_busy  (busy)
    );

    fifo_uart_tx #(.CLKS_PER_BIT(3), .STOP_BITS(2)) dut2 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_en    (en2),
        .i_empty (empty2),
        .i_data  (data2),
        .o_rd    (rd2),
        .o_tx    (tx2),
        .o_busy  (busy2)
    );

    // FIFO model: pushes from the stimulus, pops on the DUT read strobe,
    // read data appears the cycle after o_rd.
    logic [7:0] fifo_mem [64];
    int         push_total = 0;
    int         pop_total  = 0;
    assign empty = (push_total == pop_total);

    int busy_cnt = 0;
    int rd_cnt   = 0;

    always @(posedge clk) begin
        busy_cnt <= busy_cnt + (busy ? 1 : 0);
        rd_cnt   <= rd_cnt + (rd ? 1 : 0);
        if (rd && (pop_total != push_total)) begin
            data      <= fifo_mem[pop_total];
            pop_total <= pop_total + 1;
        end
    end

    logic [7:0] sb_q [$];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [7:0] w);
        fifo_mem[push_total] = w;
        push_total++;
        sb_q.push_back(w);
    endtask

    // Returns number of negedges waited until o_tx low, -1 on timeout.
    task automatic wait_start(output int n);
        n = 0;
        while (tx !== 1'b0) begin
            if (n >= 300) begin
                n = -1;
                return;
            end
            @(negedge clk);
            n++;
        end
    endtask

    // Called on the first negedge of the start bit; samples every cycle.
    task automatic rx_frame(output logic [7:0] d, output int werr);
        logic [NB-1:0] bits;
        logic          v;
        logic          s [CPB];
        werr = 0;
        for (int b = 0; b < NB; b++) begin
            for (int c = 0; c < CPB; c++) begin
                s[c] = tx;
                @(negedge clk);
            end
            v = s[CPB/2];
            for (int c = 0; c < CPB; c++) if (s[c] !== v) werr++;
            bits[b] = v;
        end
        d = bits[8:1];
        if (bits[0] !== 1'b0) werr++;
        if (bits[NB-1] !== 1'b1) werr++;
`ifdef FIFO_UART_TX_PARITY_EN
        if (bits[9] !== ^bits[8:1]) werr++;
`endif
    endtask

    task automatic rx_check(input string tag);
        logic [7:0] d;
        logic [7:0] e;
        int         werr;
        rx_frame(d, werr);
        e = 8'hxx;
        if (sb_q.size() != 0) e = sb_q.pop_front();
        chk({tag, "_data"}, {24'h0, d}, {24'h0, e});
        chk({tag, "_wave"}, werr, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int r0;
        int b0;
        int nbad;
        int lo;
        int hi;

        rst_n = 1'b0; en = 1'b0;
        en2 = 1'b0; empty2 = 1'b1; data2 = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rd", rd, 0);
        rst_n = 1'b1;

        // single frame A5
        @(negedge clk);
        en = 1'b1;
        b0 = busy_cnt; r0 = rd_cnt;
        push_word(8'hA5);
        wait_start(n);
        chk("t1_latency", n, 3);
        rx_check("t1");
        chk("t1_busy_cycles", busy_cnt - b0, 2 + NB * CPB);
        chk("t1_rd_pulses", rd_cnt - r0, 1);
        chk("t1_idle", busy, 0);

        // back-to-back frames
        r0 = rd_cnt;
        push_word(8'h11); push_word(8'h12); push_word(8'h13);
        wait_start(n);
        chk("t2_latency", n, 3);
        rx_check("t2_w0");
        wait_start(n);
        chk("t2_gap1", n, 2);
        rx_check("t2_w1");
        wait_start(n);
        chk("t2_gap2", n, 2);
        rx_check("t2_w2");
        chk("t2_rd_pulses", rd_cnt - r0, 3);
        chk("t2_idle", busy, 0);

        // enable low with data available, then enable dropped mid-frame
        en = 1'b0;
        r0 = rd_cnt; b0 = busy_cnt;
        push_word(8'h3C); push_word(8'hC3);
        nbad = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx !== 1'b1) nbad++;
        end
        chk("t3_tx_high", nbad, 0);
        chk("t3_no_rd", rd_cnt - r0, 0);
        chk("t3_no_busy", busy_cnt - b0, 0);
        en = 1'b1;
        wait_start(n);
        chk("t3_latency", n, 3);
        en = 1'b0;
        rx_check("t3_w0");
        repeat (20) @(negedge clk);
        chk("t3_rd_pulses", rd_cnt - r0, 1);
        chk("t3_idle", busy, 0);

        // reset during data bit 3 of C3
        en = 1'b1;
        r0 = rd_cnt;
        wait_start(n);
        chk("t4_latency", n, 3);
        void'(sb_q.pop_front());
        repeat (17) @(negedge clk);
        chk("t4_pre_tx", tx, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_rst_tx", tx, 1);
        chk("t4_rst_busy", busy, 0);
        chk("t4_rst_rd", rd, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("t4_no_rd", rd_cnt - r0, 1);
        chk("t4_idle", busy, 0);
        push_word(8'h5A);
        wait_start(n);
        chk("t4_post_latency", n, 3);
        rx_check("t4_w0");
        chk("t4_rd_pulses", rd_cnt - r0, 2);

        // parity patterns (plain data when parity is not built in)
        push_word(8'h07); push_word(8'h03);
        wait_start(n);
        chk("t5_latency", n, 3);
        rx_check("t5_w0");
        wait_start(n);
        chk("t5_gap", n, 2);
        rx_check("t5_w1");

        // two stop bits, 3 clocks per bit, word 00
        en2 = 1'b1; empty2 = 1'b0; data2 = 8'h00;
        n = 0;
        while (tx2 !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        lo = 0;
        while (tx2 === 1'b0 && lo < 100) begin
            lo++;
            @(negedge clk);
        end
        chk("t6_low_run", lo, 27 + 3 * PAR);
        hi = 0;
        while (rd2 !== 1'b1 && hi < 100) begin
            hi++;
            @(negedge clk);
        end
        chk("t6_stop_high", hi, 6);
        en2 = 1'b0; empty2 = 1'b1;
        hi = 0;
        while (busy2 === 1'b1 && hi < 200) begin
            hi++;
            @(negedge clk);
        end
        chk("t6_frame_cycles", hi, 2 + (NB + 1) * 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
